pl_reset_monitor: RTL and testbench
===================================

# pl_reset_monitor

Synthesizable, parametrised monitor for N_CH active-low PL reset lines, all sampled in the pl_clk0 domain. Per channel it qualifies reset release with a stability window and counts cycles spent released. It also counts reassertions and flags glitches and release timeouts. It sits beside the CIPS reset distribution and gives hardware and simulation the same reset-health view a cycle-counting bench monitor gives, plus a pollable readout port and an interrupt.

## Interface
- N_CH, 4: number of monitored reset lines (1..32)
- CNT_W, 32: width of per-channel released-cycle counter
- EVT_W, 8: width of per-channel reassertion event counter
- STABLE_CYC, 16: consecutive high samples required to declare release (>= 2)
- TIMEOUT_CYC, 1024: cycles allowed from pl_rst/clr to release before timeout (>= 1)

Ports:
- pl_clk0  in  1  monitor clock; all inputs synchronous to it
- pl_rst  in  1  synchronous, active-high reset
- mon_resetn  in  N_CH  monitored active-low resets, pre-synchronised to pl_clk0
- clr  in  N_CH  per-channel clear of counters and sticky flags
- rd_req  in  1  readout request, one per cycle allowed
- rd_ch  in  $clog2(N_CH) (min 1)  channel to read
- rd_ack  out  1  readout data valid
- rd_cycles  out  CNT_W  released-cycle count of rd_ch
- rd_events  out  EVT_W  reassertion count of rd_ch
- rd_state  out  2  FSM state of rd_ch
- released  out  N_CH  channel qualified as released
- glitch  out  N_CH  sticky: deassertion shorter than STABLE_CYC
- timeout  out  N_CH  sticky: no release within TIMEOUT_CYC
- irq  out  1  registered OR of all glitch and timeout bits

## Operation
- Per-channel FSM: ASSERTED (2'b00), QUALIFY (2'b01), RELEASED (2'b10). 2'b11 is unused and must decode to ASSERTED.
- ASSERTED: mon_resetn=1 -> QUALIFY, stab_cnt<=1.
- QUALIFY: mon_resetn=0 -> ASSERTED, glitch<=1. mon_resetn=1 and stab_cnt==STABLE_CYC-1 -> RELEASED, cycles<=0. Otherwise stab_cnt++.
- RELEASED: cycles++, saturating at all-ones. mon_resetn=0 -> ASSERTED, events++ (saturating). cycles holds its last value while not RELEASED.
- released = (state==RELEASED), registered.
- Timeout counter runs from pl_rst or clr until the channel first reaches RELEASED. On reaching TIMEOUT_CYC it sets timeout (sticky). It stops once released and stays stopped until the next clr or pl_rst.
- clr[i] zeroes cycles, events, glitch and timeout, and restarts the timeout counter. It does not change FSM state.
- clr[i] coincident with a glitch or event: clr wins; flag and counter end at 0.
- Readout: rd_req sampled at edge t gives rd_ack=1 and registered data at edge t+1. Back-to-back requests give back-to-back acks.
- rd_ch >= N_CH: rd_ack=1 with all data zero.

## Timing
- Reset values after pl_rst: all FSMs ASSERTED; all counters 0; released, glitch, timeout, irq, rd_ack, rd_* = 0.
- pl_rst mid-operation: same as above on the next edge, regardless of input activity.
- Release latency: with the first high sample at edge t and continuous high samples, released=1 after edge t+STABLE_CYC-1.
- glitch sets on the edge that samples low in QUALIFY.
- irq follows glitch and timeout by 1 cycle.
- Timeout: timeout=1 after edge TIMEOUT_CYC-1 counted from the first edge after pl_rst/clr deassertion, if the channel is not RELEASED by then.
- A release and a timeout on the same edge: release wins, timeout stays 0.
- Counters never wrap; they saturate.

## Structure
- Package pl_reset_mon_pkg holds the state enum and encodings and the constant ST_W=2.
- Sub-module pl_reset_mon_ch holds one channel: FSM, stab_cnt, timeout counter, cycles, events and flags. It is instantiated N_CH times in a generate loop.
- The top level holds the readout mux and register and the irq OR-reduce register.

## Test plan
- Defaults; pl_rst, then mon_resetn[0] high from cycle 5 -> released[0]=1 after edge 20; rd_ch=0 at cycle 30 -> rd_ack next cycle, rd_state=2, rd_cycles=10.
- mon_resetn[1] high for 5 cycles, then low -> glitch[1]=1, irq=1 one cycle later, released[1] stays 0, rd_events=0.
- mon_resetn[2] held low -> timeout[2]=1 after cycle 1024; clr[2] -> timeout[2]=0, irq=0, and the timeout fires again 1024 cycles later.
- Channel 3 released, then toggled low/high 300 times with 16+ high cycles between toggles -> rd_events=255 (saturated), rd_state=2.
- clr[1] on the same edge as a glitch -> glitch[1]=0. pl_rst mid-QUALIFY -> all outputs 0 next cycle.
- rd_req held for 4 cycles with rd_ch=0,1,2,5 -> 4 consecutive acks; the rd_ch=5 read returns all zeros.

Source files
------------

// File: rtl/pl_reset_mon_pkg.sv
// Shared types for the PL reset monitor: per-channel FSM state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pl_reset_mon_pkg;

  localparam int ST_W = 2;

  // 2'b11 is never produced; any logic decoding a state treats it as ASSERTED.
  typedef enum logic [ST_W-1:0] {
    ST_ASSERTED = 2'b00,
    ST_QUALIFY  = 2'b01,
    ST_RELEASED = 2'b10
  } ch_state_e;

endpackage

// File: rtl/pl_reset_mon_ch.sv
// One monitored reset line: release qualification FSM, release/event counters, glitch/timeout flags.
// Latency: release visible STABLE_CYC-1 edges after the first high sample; flags set on the causing edge.
// Backpressure: none; samples resetn every cycle.
// Ports: pl_clk0/pl_rst clock and sync reset; resetn monitored line; clr clears counters and flags;
//        state/released/glitch/timeout/cycles/events per-channel status, all registered.
module pl_reset_mon_ch
  import pl_reset_mon_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int EVT_W       = 8,
  parameter int STABLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             pl_clk0,
  input  logic             pl_rst,
  input  logic             resetn,
  input  logic             clr,
  output logic [ST_W-1:0]  state,
  output logic             released,
  output logic             glitch,
  output logic             timeout,
  output logic [CNT_W-1:0] cycles,
  output logic [EVT_W-1:0] events
);

  localparam int SW = $clog2(STABLE_CYC);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYC - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);

  ch_state_e st, st_nxt;
  logic [SW-1:0] stab_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_run;
  logic          go_qual, stab_inc, glitch_ev, rel_ev, drop_ev;

  always_ff @(posedge pl_clk0) begin
    if (pl_rst) st <= ST_ASSERTED;
    else        st <= st_nxt;
  end

  always_comb begin
    st_nxt    = st;
    go_qual   = 1'b0;
    stab_inc  = 1'b0;
    glitch_ev = 1'b0;
    rel_ev    = 1'b0;
    drop_ev   = 1'b0;
    case (st)
      ST_QUALIFY: begin
        if (!resetn) begin
          st_nxt    = ST_ASSERTED;
          glitch_ev = 1'b1;
        end else if (stab_cnt == STAB_LAST) begin
          st_nxt = ST_RELEASED;
          rel_ev = 1'b1;
        end else begin
          stab_inc = 1'b1;
        end
      end
      ST_RELEASED: begin
        if (!resetn) begin
          st_nxt  = ST_ASSERTED;
          drop_ev = 1'b1;
        end
      end
      default: begin
        // ASSERTED and the unused encoding behave identically.
        st_nxt = ST_ASSERTED;
        if (resetn) begin
          st_nxt  = ST_QUALIFY;
          go_qual = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge pl_clk0) begin
    if (pl_rst) begin
      stab_cnt <= '0;
      tmo_cnt  <= '0;
      tmo_run  <= 1'b1;
      cycles   <= '0;
      events   <= '0;
      glitch   <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      if (go_qual)       stab_cnt <= SW'(1);
      else if (stab_inc) stab_cnt <= stab_cnt + SW'(1);

      if (rel_ev)
        cycles <= '0;
      else if (st == ST_RELEASED && cycles != '1)
        cycles <= cycles + CNT_W'(1);

      if (drop_ev && events != '1) events <= events + EVT_W'(1);
      if (glitch_ev) glitch <= 1'b1;

      // Checking st_nxt stops the count on the release edge itself, so a
      // release coinciding with the final count suppresses the timeout.
      if (st_nxt == ST_RELEASED) begin
        tmo_run <= 1'b0;
      end else if (tmo_run) begin
        if (tmo_cnt == TMO_LAST) timeout <= 1'b1;
        else                     tmo_cnt <= tmo_cnt + TW'(1);
      end

      // Clear is last so it overrides any same-edge event.
      if (clr) begin
        cycles  <= '0;
        events  <= '0;
        glitch  <= 1'b0;
        timeout <= 1'b0;
        tmo_cnt <= '0;
        tmo_run <= 1'b1;
      end
    end
  end

  assign state    = st;
  assign released = (st == ST_RELEASED);

endmodule

// File: rtl/pl_reset_monitor.sv
// Health monitor for N_CH active-low PL resets with pollable readout and interrupt.
// Latency: readout ack/data one edge after rd_req; irq one edge after glitch/timeout.
// Backpressure: none; one readout accepted every cycle.
// Ports: mon_resetn/clr per channel; rd_req/rd_ch -> rd_ack/rd_cycles/rd_events/rd_state;
//        released/glitch/timeout per-channel status; irq = registered OR of glitch|timeout.
module pl_reset_monitor
  import pl_reset_mon_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 32,
  parameter int EVT_W       = 8,
  parameter int STABLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 1024,
  localparam int RD_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             pl_clk0,
  input  logic             pl_rst,
  input  logic [N_CH-1:0]  mon_resetn,
  input  logic [N_CH-1:0]  clr,
  input  logic             rd_req,
  input  logic [RD_W-1:0]  rd_ch,
  output logic             rd_ack,
  output logic [CNT_W-1:0] rd_cycles,
  output logic [EVT_W-1:0] rd_events,
  output logic [ST_W-1:0]  rd_state,
  output logic [N_CH-1:0]  released,
  output logic [N_CH-1:0]  glitch,
  output logic [N_CH-1:0]  timeout,
  output logic             irq
);

  logic [N_CH-1:0][CNT_W-1:0] ch_cycles;
  logic [N_CH-1:0][EVT_W-1:0] ch_events;
  logic [N_CH-1:0][ST_W-1:0]  ch_state;
  logic [CNT_W-1:0]           mux_cycles;
  logic [EVT_W-1:0]           mux_events;
  logic [ST_W-1:0]            mux_state;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    pl_reset_mon_ch #(
      .CNT_W      (CNT_W),
      .EVT_W      (EVT_W),
      .STABLE_CYC (STABLE_CYC),
      .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_ch (
      .pl_clk0 (pl_clk0),
      .pl_rst  (pl_rst),
      .resetn  (mon_resetn[g]),
      .clr     (clr[g]),
      .state   (ch_state[g]),
      .released(released[g]),
      .glitch  (glitch[g]),
      .timeout (timeout[g]),
      .cycles  (ch_cycles[g]),
      .events  (ch_events[g])
    );
  end

  // Compare-based select: a channel number with no matching instance
  // (possible when N_CH is not a power of two) falls through to zero.
  always_comb begin
    mux_cycles = '0;
    mux_events = '0;
    mux_state  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (rd_ch == RD_W'(i)) begin
        mux_cycles = ch_cycles[i];
        mux_events = ch_events[i];
        mux_state  = ch_state[i];
      end
    end
  end

  always_ff @(posedge pl_clk0) begin
    if (pl_rst) begin
      rd_ack    <= 1'b0;
      rd_cycles <= '0;
      rd_events <= '0;
      rd_state  <= '0;
      irq       <= 1'b0;
    end else begin
      rd_ack <= rd_req;
      if (rd_req) begin
        rd_cycles <= mux_cycles;
        rd_events <= mux_events;
        rd_state  <= mux_state;
      end
      irq <= (|glitch) | (|timeout);
    end
  end

endmodule

// File: tb/tb_pl_reset_monitor.sv
// Directed bench for pl_reset_monitor; N_CH=5 so that channel 5 is a real out-of-range readout.
// Latency: inputs driven 1 time unit after posedge, outputs checked at the same point.
// Backpressure: n/a.
module tb_pl_reset_monitor;

  localparam int N_CH = 5;
  localparam int CNT_W = 32;
  localparam int EVT_W = 8;

  logic             pl_clk0 = 1'b0;
  logic             pl_rst;
  logic [N_CH-1:0]  mon_resetn;
  logic [N_CH-1:0]  clr;
  logic             rd_req;
  logic [2:0]       rd_ch;
  logic             rd_ack;
  logic [CNT_W-1:0] rd_cycles;
  logic [EVT_W-1:0] rd_events;
  logic [1:0]       rd_state;
  logic [N_CH-1:0]  released;
  logic [N_CH-1:0]  glitch;
  logic [N_CH-1:0]  timeout;
  logic             irq;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  always #5 pl_clk0 = ~pl_clk0;

  pl_reset_monitor #(
    .N_CH(N_CH), .CNT_W(CNT_W), .EVT_W(EVT_W), .STABLE_CYC(16), .TIMEOUT_CYC(1024)
  ) dut (
    .pl_clk0   (pl_clk0),
    .pl_rst    (pl_rst),
    .mon_resetn(mon_resetn),
    .clr       (clr),
    .rd_req    (rd_req),
    .rd_ch     (rd_ch),
    .rd_ack    (rd_ack),
    .rd_cycles (rd_cycles),
    .rd_events (rd_events),
    .rd_state  (rd_state),
    .released  (released),
    .glitch    (glitch),
    .timeout   (timeout),
    .irq       (irq)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance n edges; cyc counts edges since pl_rst was released.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge pl_clk0);
      cyc++;
    end
    #1;
  endtask

  task automatic tick_to(input int e);
    if (cyc < e) tick(e - cyc);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_released"}, 64'(released), 64'd0);
    check({tag, "_glitch"},   64'(glitch),   64'd0);
    check({tag, "_timeout"},  64'(timeout),  64'd0);
    check({tag, "_irq"},      64'(irq),      64'd0);
    check({tag, "_rd_ack"},   64'(rd_ack),   64'd0);
    check({tag, "_rd_cyc"},   64'(rd_cycles), 64'd0);
    check({tag, "_rd_evt"},   64'(rd_events), 64'd0);
    check({tag, "_rd_st"},    64'(rd_state),  64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    pl_rst = 1'b1; mon_resetn = '0; clr = '0; rd_req = 1'b0; rd_ch = '0;
    repeat (3) @(posedge pl_clk0);
    #1;
    check_all_zero("reset");

    // Channels 3 and 4 go high straight away so they release and never time out.
    pl_rst = 1'b0; mon_resetn = 5'b11000; cyc = 0;

    // Channel 0: first high sample at edge 5, release after edge 20.
    tick(4);
    mon_resetn[0] = 1'b1;
    tick(15);
    check("rel0_edge19", 64'(released[0]), 64'd0);
    tick(1);
    check("rel_edge20", 64'(released), 64'b11001);

    // Read sampled at edge 31 returns the count after edge 30: 10 released edges.
    tick(10);
    rd_req = 1'b1; rd_ch = 3'd0;
    tick(1);
    rd_req = 1'b0;
    check("rd0_ack",   64'(rd_ack),    64'd1);
    check("rd0_state", 64'(rd_state),  64'd2);
    check("rd0_cyc",   64'(rd_cycles), 64'd10);
    check("rd0_evt",   64'(rd_events), 64'd0);
    tick(1);
    check("rd0_ack_drop", 64'(rd_ack), 64'd0);

    // Channel 1: five high samples then low -> glitch, irq one edge later.
    mon_resetn[1] = 1'b1;
    tick(5);
    check("gl1_pre", 64'(glitch[1]), 64'd0);
    mon_resetn[1] = 1'b0;
    tick(1);
    check("gl1_set",     64'(glitch[1]), 64'd1);
    check("gl1_irq_lag", 64'(irq),       64'd0);
    tick(1);
    check("gl1_irq",  64'(irq),         64'd1);
    check("gl1_rel",  64'(released[1]), 64'd0);
    rd_req = 1'b1; rd_ch = 3'd1;
    tick(1);
    rd_req = 1'b0;
    check("gl1_rd_evt", 64'(rd_events), 64'd0);
    check("gl1_rd_st",  64'(rd_state),  64'd0);

    // Clear on the same edge as a second glitch: clear wins.
    mon_resetn[1] = 1'b1;
    tick(3);
    mon_resetn[1] = 1'b0; clr[1] = 1'b1;
    tick(1);
    clr[1] = 1'b0;
    check("clr_vs_glitch", 64'(glitch[1]), 64'd0);
    tick(1);
    check("clr_irq", 64'(irq), 64'd0);
    mon_resetn[1] = 1'b1;
    tick(16);
    check("rel1", 64'(released[1]), 64'd1);

    // Channel 2 held low: timeout after edge 1024.
    tick_to(1023);
    check("tmo_1023", 64'(timeout), 64'd0);
    tick(1);
    check("tmo_1024", 64'(timeout), 64'b00100);
    check("tmo_irq_lag", 64'(irq), 64'd0);
    tick(1);
    check("tmo_irq", 64'(irq), 64'd1);
    clr[2] = 1'b1;
    tick(1);                      // clear sampled at edge 1026
    clr[2] = 1'b0;
    check("tmo_clr", 64'(timeout[2]), 64'd0);
    tick(1);
    check("tmo_clr_irq", 64'(irq), 64'd0);
    tick_to(2049);
    check("tmo2_2049", 64'(timeout[2]), 64'd0);
    tick(1);
    check("tmo2_2050", 64'(timeout[2]), 64'd1);

    // Channel 3: 300 drop/re-release cycles, event count saturates at 255.
    for (int i = 0; i < 300; i++) begin
      mon_resetn[3] = 1'b0;
      tick(1);
      mon_resetn[3] = 1'b1;
      tick(17);
      if (i == 9) begin
        rd_req = 1'b1; rd_ch = 3'd3;
        tick(1);
        rd_req = 1'b0;
        check("evt3_10", 64'(rd_events), 64'd10);
      end
    end
    check("evt3_rel", 64'(released[3]), 64'd1);
    check("evt3_glitch", 64'(glitch[3]), 64'd0);
    rd_req = 1'b1; rd_ch = 3'd3;
    tick(1);
    check("evt3_sat", 64'(rd_events), 64'd255);
    check("evt3_st",  64'(rd_state),  64'd2);

    // Back-to-back reads 0,1,2,5 then 3,5.
    rd_ch = 3'd0;
    tick(1);
    check("b2b0_ack", 64'(rd_ack), 64'd1);
    check("b2b0_cyc", 64'(rd_cycles), 64'(cyc - 1 - 20));
    rd_ch = 3'd1;
    tick(1);
    check("b2b1_ack", 64'(rd_ack), 64'd1);
    check("b2b1_st",  64'(rd_state), 64'd2);
    rd_ch = 3'd2;
    tick(1);
    check("b2b2_ack", 64'(rd_ack), 64'd1);
    check("b2b2_st",  64'(rd_state), 64'd0);
    rd_ch = 3'd5;
    tick(1);
    check("b2b5_ack", 64'(rd_ack), 64'd1);
    check("b2b5_data", 64'({rd_cycles, rd_events, rd_state}), 64'd0);
    rd_ch = 3'd3;
    tick(1);
    check("b2b3_evt", 64'(rd_events), 64'd255);
    rd_ch = 3'd5;
    tick(1);
    check("b2b5b_ack", 64'(rd_ack), 64'd1);
    check("b2b5b_data", 64'({rd_cycles, rd_events, rd_state}), 64'd0);

    // pl_rst with channel 2 in QUALIFY and a read pending: everything clears.
    rd_ch = 3'd3;
    mon_resetn[2] = 1'b1;
    tick(3);
    pl_rst = 1'b1;
    tick(1);
    rd_req = 1'b0;
    check_all_zero("midrst");
    pl_rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
